nexi_uart_fifo_wb: RTL and testbench

NEXI_UART_FIFO_WB -- requirements
Module: nexi_uart_fifo_wb

---
 rtl/nexi_uart_pkg.sv | 35 +++
 rtl/nexi_uart_sync_fifo.sv | 64 ++++++
 rtl/nexi_uart_fifo_wb.sv | 278 +++++++++++++++++++++++++++
 tb/tb_nexi_uart_fifo_wb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nexi_uart_pkg.sv
// Shared constants for the NEXI Wishbone UART: register addresses, STATUS bit
// positions and the TX/RX state encodings.
package nexi_uart_pkg;

    localparam logic [2:0] ADDR_RXDATA = 3'd0;
    localparam logic [2:0] ADDR_TXDATA = 3'd1;
    localparam logic [2:0] ADDR_IER    = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_DIV_LO = 3'd4;
    localparam logic [2:0] ADDR_DIV_HI = 3'd5;
    localparam logic [2:0] ADDR_RXTHR  = 3'd6;
    localparam logic [2:0] ADDR_LEVEL  = 3'd7;

    localparam int ST_RX_NOT_EMPTY = 0;
    localparam int ST_RX_FULL      = 1;
    localparam int ST_TX_FULL      = 2;
    localparam int ST_TX_IDLE      = 3;
    localparam int ST_OVERRUN      = 4;
    localparam int ST_FRAMING_ERR  = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/nexi_uart_sync_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through read data.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module nexi_uart_sync_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push,
    input  logic                        pop,
    input  logic [7:0]                  wdata,
    output logic [7:0]                  rdata,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the current fill level
    always_comb begin
        empty     = (count_r == {(PTR_W+1){1'b0}});
        full      = (count_r == (PTR_W+1)'(FIFO_DEPTH));
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop);
        count     = count_r;
        rdata     = mem_r[rd_ptr_r];
    end

    // Storage array, no reset needed since empty slots are never observed
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/nexi_uart_fifo_wb.sv
// Wishbone-classic 8N1 UART with TX/RX FIFOs, programmable divisor and level IRQ.
// The TX byte stays at the FIFO head until its stop bit ends, so a full FIFO means 16 pending bytes.
module nexi_uart_fifo_wb
    import nexi_uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [2:0] addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       ack_o,
    output logic       irq_o,
    input  logic       rx_pin,
    output logic       tx_pin
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             ack_r, irq_r, tx_pin_r, ovr_r, fe_r;
    logic [7:0]       data_r;
    logic [2:0]       ier_r;
    logic [CNT_W-1:0] rxthr_r, rxthr_wr_s;
    logic [DIV_W-1:0] div_r, div_eff_s, div_reload_s, rx_half_s;
    logic             req_s, sts_wr_s, tx_idle_s, irq_nxt_s;
    logic [7:0]       rd_val_s, status_s, level_s;

    logic             tx_push_s, tx_pop_s, tx_full_s, tx_empty_s, tx_more_s, tx_tick_s, tx_pin_nxt_s;
    logic [CNT_W-1:0] tx_count_s;
    logic [7:0]       tx_head_s;
    tx_state_e        tx_state_r, tx_state_nxt_s;
    logic [DIV_W-1:0] tx_cnt_r;
    logic [2:0]       tx_bit_r;

    logic             rx_meta_r, rx_sync_r, rx_tick_s;
    logic             rx_push_s, rx_pop_s, rx_full_s, rx_empty_s, rx_fe_s, rx_drop_s;
    logic [CNT_W-1:0] rx_count_s;
    logic [7:0]       rx_head_s, rx_shift_r;
    rx_state_e        rx_state_r, rx_state_nxt_s;
    logic [DIV_W-1:0] rx_cnt_r;
    logic [2:0]       rx_bit_r;

    assign ack_o  = ack_r;
    assign data_o = data_r;
    assign irq_o  = irq_r;
    assign tx_pin = tx_pin_r;

    nexi_uart_sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push(tx_push_s), .pop(tx_pop_s), .wdata(data_i),
        .rdata(tx_head_s), .full(tx_full_s), .empty(tx_empty_s), .count(tx_count_s)
    );

    nexi_uart_sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push(rx_push_s), .pop(rx_pop_s), .wdata(rx_shift_r),
        .rdata(rx_head_s), .full(rx_full_s), .empty(rx_empty_s), .count(rx_count_s)
    );

    // Bus decode, divisor helpers and derived status
    always_comb begin
        req_s        = cyc_i & stb_i & ~ack_r;
        sts_wr_s     = req_s & we_i & (addr_i == ADDR_STATUS);
        tx_push_s    = req_s & we_i & (addr_i == ADDR_TXDATA);
        rx_pop_s     = req_s & ~we_i & (addr_i == ADDR_RXDATA) & ~rx_empty_s;
        div_eff_s    = (div_r == {DIV_W{1'b0}}) ? DIV_W'(1'b1) : div_r;
        div_reload_s = div_eff_s - DIV_W'(1'b1);
        rx_half_s    = div_eff_s >> 1'b1;
        tx_idle_s    = tx_empty_s & (tx_state_r == TX_IDLE);
        level_s      = (32'(rx_count_s) > 32'd255) ? 8'hFF : 8'(rx_count_s);
        status_s     = 8'h00;
        status_s[ST_RX_NOT_EMPTY] = ~rx_empty_s;
        status_s[ST_RX_FULL]      = rx_full_s;
        status_s[ST_TX_FULL]      = tx_full_s;
        status_s[ST_TX_IDLE]      = tx_idle_s;
        status_s[ST_OVERRUN]      = ovr_r;
        status_s[ST_FRAMING_ERR]  = fe_r;
        irq_nxt_s = (ier_r[0] & (rx_count_s >= rxthr_r)) | (ier_r[1] & tx_idle_s) |
                    (ier_r[2] & (ovr_r | fe_r));
    end

    // RXTHR writes are clamped into 1..FIFO_DEPTH
    always_comb begin
        if (data_i == 8'd0) begin
            rxthr_wr_s = CNT_W'(1'b1);
        end else if (32'(data_i) > FIFO_DEPTH) begin
            rxthr_wr_s = CNT_W'(FIFO_DEPTH);
        end else begin
            rxthr_wr_s = CNT_W'(data_i);
        end
    end

    // Read data mux
    always_comb begin
        rd_val_s = 8'h00;
        case (addr_i)
            ADDR_RXDATA: rd_val_s = rx_empty_s ? 8'h00 : rx_head_s;
            ADDR_IER:    rd_val_s = {5'd0, ier_r};
            ADDR_STATUS: rd_val_s = status_s;
            ADDR_DIV_LO: rd_val_s = div_r[7:0];
            ADDR_DIV_HI: rd_val_s = 8'(div_r >> 4'd8);
            ADDR_RXTHR:  rd_val_s = 8'(rxthr_r);
            ADDR_LEVEL:  rd_val_s = level_s;
            default:     rd_val_s = 8'h00;
        endcase
    end

    // Bus handshake, read capture and control register writes
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ack_r   <= 1'b0;
            data_r  <= 8'h00;
            ier_r   <= 3'd0;
            rxthr_r <= CNT_W'(1'b1);
            div_r   <= DIV_W'(DEFAULT_DIV);
        end else begin
            ack_r <= req_s;
            if (req_s) begin
                data_r <= rd_val_s;
            end
            if (req_s && we_i) begin
                case (addr_i)
                    ADDR_IER:    ier_r   <= data_i[2:0];
                    ADDR_DIV_LO: div_r   <= (div_r & ~DIV_W'(8'hFF)) | DIV_W'(data_i);
                    ADDR_DIV_HI: div_r   <= (div_r & DIV_W'(8'hFF)) | (DIV_W'(data_i) << 4'd8);
                    ADDR_RXTHR:  rxthr_r <= rxthr_wr_s;
                    default:     begin end
                endcase
            end
        end
    end

    // Sticky error flags; a new event wins over a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovr_r <= 1'b0;
            fe_r  <= 1'b0;
        end else begin
            ovr_r <= (ovr_r & ~(sts_wr_s & data_i[ST_OVERRUN])) | rx_drop_s;
            fe_r  <= (fe_r & ~(sts_wr_s & data_i[ST_FRAMING_ERR])) | rx_fe_s;
        end
    end

    // Registered interrupt and serial output
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_r    <= 1'b0;
            tx_pin_r <= 1'b1;
        end else begin
            irq_r    <= irq_nxt_s;
            tx_pin_r <= tx_pin_nxt_s;
        end
    end

    // TX state register; the bit timer reloads only at bit boundaries
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= {DIV_W{1'b0}};
            tx_bit_r   <= 3'd0;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            if ((tx_state_r == TX_IDLE) || tx_tick_s) begin
                tx_cnt_r <= div_reload_s;
            end else begin
                tx_cnt_r <= tx_cnt_r - DIV_W'(1'b1);
            end
            if (tx_state_r != TX_DATA) begin
                tx_bit_r <= 3'd0;
            end else if (tx_tick_s) begin
                tx_bit_r <= tx_bit_r + 3'd1;
            end
        end
    end

    // TX next state; a pending byte at the end of STOP starts the next frame at once
    always_comb begin
        tx_tick_s      = (tx_cnt_r == {DIV_W{1'b0}});
        tx_more_s      = (tx_count_s > CNT_W'(1'b1)) | tx_push_s;
        tx_state_nxt_s = tx_state_r;
        case (tx_state_r)
            TX_IDLE:  tx_state_nxt_s = tx_empty_s ? TX_IDLE : TX_START;
            TX_START: tx_state_nxt_s = tx_tick_s ? TX_DATA : TX_START;
            TX_DATA:  tx_state_nxt_s = (tx_tick_s && (tx_bit_r == 3'd7)) ? TX_STOP : TX_DATA;
            TX_STOP:  begin
                if (tx_tick_s) begin
                    tx_state_nxt_s = tx_more_s ? TX_START : TX_IDLE;
                end else begin
                    tx_state_nxt_s = TX_STOP;
                end
            end
            default:  tx_state_nxt_s = TX_IDLE;
        endcase
    end

    // TX outputs: line level and FIFO pop when the stop bit completes
    always_comb begin
        tx_pop_s = (tx_state_r == TX_STOP) & tx_tick_s;
        case (tx_state_r)
            TX_START: tx_pin_nxt_s = 1'b0;
            TX_DATA:  tx_pin_nxt_s = tx_head_s[tx_bit_r];
            default:  tx_pin_nxt_s = 1'b1;
        endcase
    end

    // Two-flop synchroniser on the serial input
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_pin;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX state register, half-bit start timer and data shifter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= {DIV_W{1'b0}};
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_state_r <= rx_state_nxt_s;
            if (rx_state_r == RX_IDLE) begin
                rx_cnt_r <= (rx_half_s == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : rx_half_s - DIV_W'(1'b1);
            end else if (rx_tick_s) begin
                rx_cnt_r <= div_reload_s;
            end else begin
                rx_cnt_r <= rx_cnt_r - DIV_W'(1'b1);
            end
            if (rx_state_r != RX_DATA) begin
                rx_bit_r <= 3'd0;
            end else if (rx_tick_s) begin
                rx_bit_r   <= rx_bit_r + 3'd1;
                rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            end
        end
    end

    // RX next state; with a 1-cycle bit the falling edge itself is the start sample
    always_comb begin
        rx_tick_s      = (rx_cnt_r == {DIV_W{1'b0}});
        rx_state_nxt_s = rx_state_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (!rx_sync_r) begin
                    rx_state_nxt_s = (rx_half_s == {DIV_W{1'b0}}) ? RX_DATA : RX_START;
                end else begin
                    rx_state_nxt_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_tick_s) begin
                    rx_state_nxt_s = rx_sync_r ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_nxt_s = RX_START;
                end
            end
            RX_DATA: rx_state_nxt_s = (rx_tick_s && (rx_bit_r == 3'd7)) ? RX_STOP : RX_DATA;
            RX_STOP: rx_state_nxt_s = rx_tick_s ? RX_IDLE : RX_STOP;
            default: rx_state_nxt_s = RX_IDLE;
        endcase
    end

    // RX outputs: push on a good stop bit, flag a bad one, detect overrun
    always_comb begin
        rx_push_s = (rx_state_r == RX_STOP) & rx_tick_s & rx_sync_r;
        rx_fe_s   = (rx_state_r == RX_STOP) & rx_tick_s & ~rx_sync_r;
        rx_drop_s = rx_push_s & rx_full_s & ~rx_pop_s;
    end

endmodule

// File: tb/tb_nexi_uart_fifo_wb.sv
// Self-checking bench for nexi_uart_fifo_wb: register table, loopback with a
// queue-based reference model, and hand-written overrun/glitch/reset sequences.
module tb_nexi_uart_fifo_wb;

    localparam logic [2:0] A_RX = 3'd0, A_TX = 3'd1, A_IER = 3'd2, A_ST = 3'd3;
    localparam logic [2:0] A_DLO = 3'd4, A_DHI = 3'd5, A_THR = 3'd6, A_LVL = 3'd7;

    logic clk = 1'b0;
    logic rst_n, cyc, stb, we, ack, irq, rx_pin, tx_pin, loop_en, rx_drv;
    logic [2:0] addr;
    logic [7:0] wdat, rdat;
    int n_checks = 0;
    int n_errors = 0;
    int last_lat = 0;

    always #5 clk = ~clk;
    assign rx_pin = loop_en ? tx_pin : rx_drv;

    nexi_uart_fifo_wb dut (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .addr_i(addr), .data_i(wdat), .data_o(rdat), .ack_o(ack),
        .irq_o(irq), .rx_pin(rx_pin), .tx_pin(tx_pin)
    );

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_val;
        string      name;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [7:0] d, output logic [7:0] q);
        logic got;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                last_lat = i + 1;
                break;
            end
        end
        q = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) check("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] q;
        wb_xfer(1'b1, a, d, q);
    endtask

    task automatic wb_rd(input logic [2:0] a, output logic [7:0] q);
        wb_xfer(1'b0, a, 8'h00, q);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_div(input logic [7:0] d);
        wb_wr(A_DLO, d);
        wb_wr(A_DHI, 8'h00);
    endtask

    // Drive one 8N1 frame on rx_drv, d cycles per bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int d);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            repeat (d) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q, b;
        logic [7:0] exp_q[$];
        logic [9:0] samp;
        int d, dd, n, thr, waited;
        logic rose;

        tbl[0]  = '{1'b0, A_ST,  8'h00, 8'h08, "status_rst"};
        tbl[1]  = '{1'b0, A_RX,  8'h00, 8'h00, "rxdata_empty"};
        tbl[2]  = '{1'b0, A_LVL, 8'h00, 8'h00, "level_rst"};
        tbl[3]  = '{1'b0, A_IER, 8'h00, 8'h00, "ier_rst"};
        tbl[4]  = '{1'b0, A_THR, 8'h00, 8'h01, "rxthr_rst"};
        tbl[5]  = '{1'b0, A_DLO, 8'h00, 8'h64, "div_lo_rst"};
        tbl[6]  = '{1'b0, A_DHI, 8'h00, 8'h03, "div_hi_rst"};
        tbl[7]  = '{1'b1, A_IER, 8'hFF, 8'h07, "ier_mask"};
        tbl[8]  = '{1'b1, A_DLO, 8'hA5, 8'hA5, "div_lo_wr"};
        tbl[9]  = '{1'b1, A_DHI, 8'h5A, 8'h5A, "div_hi_wr"};
        tbl[10] = '{1'b1, A_THR, 8'h10, 8'h10, "rxthr_max"};
        tbl[11] = '{1'b1, A_ST,  8'hFF, 8'h08, "status_ro"};
        tbl[12] = '{1'b1, A_IER, 8'h00, 8'h00, "ier_clear"};

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 3'd0; wdat = 8'h00;
        loop_en = 1'b0; rx_drv = 1'b1;
        cycles(3);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", 32'(rdat), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_tx_pin", 32'(tx_pin), 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].we) wb_wr(tbl[i].addr, tbl[i].wdata);
            wb_rd(tbl[i].addr, q);
            check(tbl[i].name, 32'(q), 32'(tbl[i].exp_val));
        end
        check("ack_latency", 32'(last_lat), 32'd1);

        // Loopback single byte with RX-level interrupt
        set_div(8'd4);
        wb_wr(A_THR, 8'd1);
        wb_wr(A_IER, 8'h01);
        loop_en = 1'b1;
        wb_wr(A_TX, 8'h55);
        check("irq_before", 32'(irq), 32'd0);
        cycles(1);
        check("ack_one_cycle", 32'(ack), 32'd0);
        rose = 1'b0; waited = 0;
        for (int i = 0; i < 200; i++) begin
            if (irq) begin
                rose = 1'b1;
                break;
            end
            waited++;
            cycles(1);
        end
        check("irq_rise_after_frame", 32'(rose && waited >= 36), 32'd1);
        wb_rd(A_RX, q);
        check("loop_rxdata", 32'(q), 32'h55);
        cycles(2);
        check("irq_after_pop", 32'(irq), 32'd0);

        // TX FIFO full: the 17th byte is dropped
        wb_wr(A_IER, 8'h00);
        set_div(8'd8);
        for (int i = 0; i <= 16; i++) wb_wr(A_TX, 8'(i));
        wb_rd(A_ST, q);
        check("tx_full", 32'(q[2]), 32'd1);
        cycles(16 * 80 + 120);
        wb_rd(A_LVL, q);
        check("txfull_level", 32'(q), 32'd16);
        for (int i = 0; i < 16; i++) begin
            wb_rd(A_RX, q);
            check("txfull_byte", 32'(q), 32'(i));
        end
        wb_rd(A_ST, q);
        check("txfull_status_end", 32'(q), 32'h08);

        // Randomised loopback against a queue model
        for (int it = 0; it < 3; it++) begin
            d = $urandom_range(0, 6);
            dd = (d == 0) ? 1 : d;
            n = $urandom_range(1, 16);
            thr = $urandom_range(1, 16);
            set_div(8'(d));
            wb_wr(A_THR, 8'(thr));
            wb_wr(A_IER, 8'h01);
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                wb_wr(A_TX, b);
            end
            cycles(n * 10 * dd + 60);
            check("rand_irq", 32'(irq), 32'(n >= thr));
            wb_rd(A_LVL, q);
            check("rand_level", 32'(q), 32'(exp_q.size()));
            while (exp_q.size() > 0) begin
                wb_rd(A_RX, q);
                check("rand_byte", 32'(q), 32'(exp_q.pop_front()));
            end
            wb_rd(A_ST, q);
            check("rand_status", 32'(q), 32'h08);
        end

        // Overrun: 17 frames without reading
        loop_en = 1'b0;
        set_div(8'd4);
        wb_wr(A_IER, 8'h04);
        exp_q.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 16) exp_q.push_back(b);
            send_frame(b, 1'b1, 4);
        end
        cycles(20);
        wb_rd(A_LVL, q);
        check("ovr_level", 32'(q), 32'd16);
        wb_rd(A_ST, q);
        check("ovr_status", 32'(q), 32'h1B);
        check("ovr_irq", 32'(irq), 32'd1);
        wb_wr(A_ST, 8'h10);
        wb_rd(A_ST, q);
        check("ovr_cleared", 32'(q), 32'h0B);
        cycles(2);
        check("ovr_irq_clear", 32'(irq), 32'd0);
        while (exp_q.size() > 0) begin
            wb_rd(A_RX, q);
            check("ovr_byte", 32'(q), 32'(exp_q.pop_front()));
        end

        // Short glitch is a false start; low stop bit is a framing error
        set_div(8'd8);
        cycles(1);
        rx_drv = 1'b0;
        cycles(2);
        rx_drv = 1'b1;
        cycles(40);
        wb_rd(A_ST, q);
        check("glitch_status", 32'(q), 32'h08);
        send_frame(8'($urandom_range(0, 255)), 1'b0, 8);
        cycles(40);
        wb_rd(A_ST, q);
        check("framing_status", 32'(q), 32'h28);
        wb_rd(A_LVL, q);
        check("framing_level", 32'(q), 32'd0);
        check("framing_irq", 32'(irq), 32'd1);

        // Reset in the middle of a TX byte
        set_div(8'd4);
        wb_wr(A_TX, 8'h00);
        cycles(15);
        check("tx_low_mid_byte", 32'(tx_pin), 32'd0);
        rst_n = 1'b0;
        cycles(1);
        check("rst_mid_tx_pin", 32'(tx_pin), 32'd1);
        check("rst_mid_irq", 32'(irq), 32'd0);
        cycles(1);
        rst_n = 1'b1;
        cycles(4);
        check("post_rst_tx_pin", 32'(tx_pin), 32'd1);
        wb_rd(A_ST, q);
        check("post_rst_status", 32'(q), 32'h08);
        wb_rd(A_RX, q);
        check("post_rst_rxdata", 32'(q), 32'h00);

        // DIV=0 gives a one-cycle bit period
        set_div(8'd0);
        b = 8'($urandom_range(0, 255));
        wb_wr(A_TX, b);
        rose = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (tx_pin == 1'b0) begin
                rose = 1'b1;
                break;
            end
        end
        check("div0_start_seen", 32'(rose), 32'd1);
        samp[0] = tx_pin;
        for (int i = 1; i < 10; i++) begin
            cycles(1);
            samp[i] = tx_pin;
        end
        check("div0_frame", 32'(samp), 32'({1'b1, b, 1'b0}));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
